spi_adc_rx_multi: RTL and testbench

- Parametrised, fully synchronous SPI slave receiver for multi-channel ADC/MCU control frames. Next generation of the single-frame SPI input stage.
- SPI pins are oversampled in the system clock domain, glitch-filtered and edge-detected, so no logic is clocked by spi_clock_in.
- Receives NUM_CHANNELS words of WORD_WIDTH bits per nss frame, in any SPI mode, with configurable bit order.
- Output registers are double-buffered and update atomically on a complete frame. Sits between the external ADC/MCU SPI pins and the oscillator/parameter logic.

---
 rtl/spi_adc_rx_multi_pkg.sv | 26 ++
 rtl/spi_adc_rx_multi_if.sv | 40 ++++
 rtl/spi_adc_rx_multi_pin_filter.sv | 57 +++++
 rtl/spi_adc_rx_multi.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_adc_rx_multi.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_rx_multi_pkg.sv
// spi_adc_rx_multi shared package
// FSM encoding, SPI mode helpers and counter width helper
package spi_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_DONE
  } rx_state_e;

  // modes 0/3 sample on the rising sclk edge
  function automatic logic sample_on_rise(int mode);
    return (mode == 0) || (mode == 3);
  endfunction

  // CPOL: sclk idles high in modes 2/3
  function automatic logic idle_sclk(int mode);
    return (mode >= 2);
  endfunction

  // bits needed to hold values 0..n-1
  function automatic int cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_adc_rx_multi_if.sv
// spi_adc_rx_multi pin and result bundle
// master drives SPI pins, slave is the receiver
interface spi_adc_rx_multi_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int WORD_WIDTH   = 16
);
  import spi_rx_pkg::*;

  logic                               spi_nss;
  logic                               spi_clock_in;
  logic                               spi_data_in;
  logic [NUM_CHANNELS*WORD_WIDTH-1:0] data_out;
  logic                               data_valid;
  logic                               frame_error;
  logic                               checksum_error;
  logic                               busy;

  modport slave (
    input  spi_nss,
    input  spi_clock_in,
    input  spi_data_in,
    output data_out,
    output data_valid,
    output frame_error,
    output checksum_error,
    output busy
  );

  modport master (
    output spi_nss,
    output spi_clock_in,
    output spi_data_in,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  checksum_error,
    input  busy
  );

endinterface

// File: rtl/spi_adc_rx_multi_pin_filter.sv
// spi_pin_filter: 2-FF sync plus stability counter
// level flips after FILTER_LEN identical differing samples
module spi_pin_filter
  import spi_rx_pkg::*;
#(
  parameter int   FILTER_LEN = 3,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;
  logic       w_s;
  logic       w_done;

  assign w_s    = r_sync[1];
  assign w_done = (r_cnt == 4'(FILTER_LEN - 1));

  // synchronise, then accept a new level only once it has held
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= {2{RST_VAL}};
      r_cnt   <= '0;
      r_level <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_adc_rx_multi.sv
// spi_adc_rx_multi: oversampled multi-word SPI slave receiver
// optional trailing checksum word: define SPI_RX_CHECKSUM_EN
module spi_adc_rx_multi
  import spi_rx_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int SPI_MODE     = 0,
  parameter int MSB_FIRST    = 1,
  parameter int FILTER_LEN   = 3
) (
  input logic               clock,
  input logic               reset,
  spi_adc_rx_multi_if.slave bus
);

  localparam int DW = NUM_CHANNELS * WORD_WIDTH;
`ifdef SPI_RX_CHECKSUM_EN
  localparam int NW = NUM_CHANNELS + 1;
`else
  localparam int NW = NUM_CHANNELS;
`endif
  localparam int   BC_W        = cnt_w(WORD_WIDTH);
  localparam int   WC_W        = cnt_w(NW + 1);
  localparam logic SAMPLE_RISE = sample_on_rise(SPI_MODE);
  localparam logic SCLK_IDLE   = idle_sclk(SPI_MODE);

  logic w_sclk_lvl;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_nss_lvl;
  logic w_nss_rise;
  logic w_nss_fall;
  logic w_strobe;
  logic w_mosi;

  spi_pin_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (SCLK_IDLE)
  ) u_sclk_flt (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_pin   (bus.spi_clock_in),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_pin_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b1)
  ) u_nss_flt (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_pin   (bus.spi_nss),
    .o_level (w_nss_lvl),
    .o_rise  (w_nss_rise),
    .o_fall  (w_nss_fall)
  );

  // an edge strobe whose new level matches the sampling polarity
  assign w_strobe = (w_sclk_rise | w_sclk_fall)
                  & (w_sclk_lvl == SAMPLE_RISE);

  logic [1:0]            r_mosi_sync;
  logic [FILTER_LEN-1:0] r_mosi_dly;

  // sync mosi and delay it by the sclk filter latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mosi_sync <= '0;
      r_mosi_dly  <= '0;
    end else begin
      r_mosi_sync   <= {r_mosi_sync[0], bus.spi_data_in};
      r_mosi_dly[0] <= r_mosi_sync[1];
      for (int i = 1; i < FILTER_LEN; i++)
        r_mosi_dly[i] <= r_mosi_dly[i-1];
    end
  end

  assign w_mosi = r_mosi_dly[FILTER_LEN-1];

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [BC_W-1:0]       r_bit_cnt;
  logic [WC_W-1:0]       r_word_cnt;
  logic [WORD_WIDTH-1:0] r_sh;
  logic [WORD_WIDTH-1:0] w_sh_nxt;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_data_out;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  w_start;
  logic                  w_shift;
  logic                  w_last;
  logic                  w_ferr;
  logic                  w_word_end;
  logic                  w_final;

  assign w_word_end = (r_bit_cnt == BC_W'(WORD_WIDTH - 1));
  assign w_final    = w_word_end
                    && (r_word_cnt == WC_W'(NW - 1));

  // next shift register value for the current bit
  always_comb begin
    w_sh_nxt = r_sh;
    if (MSB_FIRST != 0)
      w_sh_nxt = {r_sh[WORD_WIDTH-2:0], w_mosi};
    else
      w_sh_nxt = {w_mosi, r_sh[WORD_WIDTH-1:1]};
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and datapath controls; nss beats a strobe
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_nss_fall) begin
          w_state_nxt = ST_RECEIVE;
          w_start     = 1'b1;
        end
      end
      ST_RECEIVE: begin
        if (w_nss_rise || w_nss_lvl) begin
          w_state_nxt = ST_IDLE;
          w_ferr      = 1'b1;
        end else if (w_strobe) begin
          w_shift = 1'b1;
          if (w_final) begin
            w_last      = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (w_nss_rise || w_nss_lvl)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SPI_RX_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_sum;
  logic                  r_cerr;
`else
  logic [DW-1:0]         w_frame;

  // shadow merged with the word completing right now
  always_comb begin
    w_frame = r_shadow;
    w_frame[(NUM_CHANNELS-1)*WORD_WIDTH +: WORD_WIDTH] = w_sh_nxt;
  end
`endif

  // shift, count, buffer words and publish complete frames
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_sh       <= '0;
      r_shadow   <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
      r_sum      <= '0;
      r_cerr     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= w_ferr;
`ifdef SPI_RX_CHECKSUM_EN
      r_cerr  <= 1'b0;
`endif
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_sh       <= '0;
`ifdef SPI_RX_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end else if (w_shift) begin
        r_sh <= w_sh_nxt;
        if (w_word_end) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= r_word_cnt + 1'b1;
          for (int k = 0; k < NUM_CHANNELS; k++)
            if (r_word_cnt == WC_W'(k))
              r_shadow[k*WORD_WIDTH +: WORD_WIDTH] <= w_sh_nxt;
`ifdef SPI_RX_CHECKSUM_EN
          if (r_word_cnt < WC_W'(NUM_CHANNELS))
            r_sum <= r_sum + w_sh_nxt;
`endif
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_last) begin
`ifdef SPI_RX_CHECKSUM_EN
          if (w_sh_nxt == r_sum) begin
            r_data_out <= r_shadow;
            r_valid    <= 1'b1;
          end else begin
            r_cerr <= 1'b1;
          end
`else
          r_data_out <= w_frame;
          r_valid    <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_valid;
  assign bus.frame_error = r_ferr;
  assign bus.busy        = (r_state != ST_IDLE);
`ifdef SPI_RX_CHECKSUM_EN
  assign bus.checksum_error = r_cerr;
`else
  assign bus.checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_rx_multi.sv
// tb_spi_adc_rx_multi: directed frames on two configurations
// dut0 mode0 W16 N2 MSB-first, dut1 mode1 W8 N4 LSB-first
module tb_spi_adc_rx_multi;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic nss_p  [2];
  logic sck_p  [2];
  logic mosi_p [2];

  spi_adc_rx_multi_if #(.NUM_CHANNELS(2), .WORD_WIDTH(16)) if0 ();
  spi_adc_rx_multi_if #(.NUM_CHANNELS(4), .WORD_WIDTH(8))  if1 ();

  assign if0.spi_nss      = nss_p[0];
  assign if0.spi_clock_in = sck_p[0];
  assign if0.spi_data_in  = mosi_p[0];
  assign if1.spi_nss      = nss_p[1];
  assign if1.spi_clock_in = sck_p[1];
  assign if1.spi_data_in  = mosi_p[1];

  spi_adc_rx_multi #(
    .WORD_WIDTH(16), .NUM_CHANNELS(2), .SPI_MODE(0),
    .MSB_FIRST(1), .FILTER_LEN(3)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0)
  );

  spi_adc_rx_multi #(
    .WORD_WIDTH(8), .NUM_CHANNELS(4), .SPI_MODE(1),
    .MSB_FIRST(0), .FILTER_LEN(3)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int nv [2] = '{0, 0};
  int nf [2] = '{0, 0};
  int nc [2] = '{0, 0};

  always @(negedge clock) begin
    if (if0.data_valid)     nv[0]++;
    if (if1.data_valid)     nv[1]++;
    if (if0.frame_error)    nf[0]++;
    if (if1.frame_error)    nf[1]++;
    if (if0.checksum_error) nc[0]++;
    if (if1.checksum_error) nc[1]++;
  end

  task automatic check(string tag, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(int d, logic b, int mode, bit g);
    if (mode == 0) begin
      mosi_p[d] = b;
      cyc(8);
      sck_p[d] = 1'b1;
      if (g) begin
        cyc(5);
        sck_p[d] = 1'b0;
        cyc(1);
        sck_p[d] = 1'b1;
        cyc(2);
      end else begin
        cyc(8);
      end
      sck_p[d] = 1'b0;
    end else begin
      sck_p[d]  = 1'b1;
      mosi_p[d] = b;
      cyc(8);
      sck_p[d] = 1'b0;
      cyc(8);
    end
  endtask

  task automatic send_word(int d, logic [31:0] w, int wid,
                           bit msb, int mode, int gbit);
    for (int i = 0; i < wid; i++) begin
      int idx;
      idx = msb ? (wid - 1 - i) : i;
      send_bit(d, w[idx], mode, (i == gbit));
    end
  endtask

  task automatic begin_f(int d);
    nss_p[d] = 1'b0;
    cyc(8);
  endtask

  task automatic end_f(int d);
    cyc(8);
    nss_p[d] = 1'b1;
    cyc(16);
  endtask

  task automatic words0(logic [15:0] a, logic [15:0] b, int g);
    send_word(0, {16'h0, a}, 16, 1'b1, 0, g);
    send_word(0, {16'h0, b}, 16, 1'b1, 0, -1);
`ifdef SPI_RX_CHECKSUM_EN
    send_word(0, {16'h0, a + b}, 16, 1'b1, 0, -1);
`endif
  endtask

  task automatic frame0(logic [15:0] a, logic [15:0] b, int g);
    begin_f(0);
    words0(a, b, g);
    end_f(0);
  endtask

  int v0;
  int f0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      nss_p[i]  = 1'b1;
      sck_p[i]  = 1'b0;
      mosi_p[i] = 1'b0;
    end
    cyc(5);
    check("rst_dout0", 64'(if0.data_out), 64'h0);
    check("rst_busy0", 64'(if0.busy), 64'h0);
    check("rst_valid0", 64'(if0.data_valid), 64'h0);
    check("rst_ferr0", 64'(if0.frame_error), 64'h0);
    check("rst_cerr0", 64'(if0.checksum_error), 64'h0);
    check("rst_dout1", 64'(if1.data_out), 64'h0);
    check("rst_busy1", 64'(if1.busy), 64'h0);
    reset = 1'b1;
    cyc(10);

    v0 = nv[0];
    f0 = nf[0];
    begin_f(0);
    check("f1_busy_mid", 64'(if0.busy), 64'h1);
    words0(16'hA5C3, 16'h1234, -1);
    end_f(0);
    check("f1_dout", 64'(if0.data_out), 64'h1234A5C3);
    check("f1_valid_cnt", 64'(nv[0] - v0), 64'd1);
    check("f1_busy_end", 64'(if0.busy), 64'h0);
    check("f1_ferr_cnt", 64'(nf[0] - f0), 64'd0);

    v0 = nv[0];
    frame0(16'h8001, 16'h7FFE, 5);
    check("f2_glitch_dout", 64'(if0.data_out), 64'h7FFE8001);
    check("f2_valid_cnt", 64'(nv[0] - v0), 64'd1);

    frame0(16'hA5C3, 16'h1234, -1);
    check("f3_dout", 64'(if0.data_out), 64'h1234A5C3);

    v0 = nv[0];
    f0 = nf[0];
    begin_f(0);
    send_word(0, 32'h0000A5C3, 16, 1'b1, 0, -1);
    send_word(0, 32'h00000001, 4, 1'b1, 0, -1);
    end_f(0);
    check("f4_ferr_cnt", 64'(nf[0] - f0), 64'd1);
    check("f4_valid_cnt", 64'(nv[0] - v0), 64'd0);
    check("f4_dout_hold", 64'(if0.data_out), 64'h1234A5C3);
    check("f4_busy_end", 64'(if0.busy), 64'h0);

    frame0(16'hFFFF, 16'h0001, -1);
    check("f5_dout", 64'(if0.data_out), 64'h0001FFFF);

    v0 = nv[1];
    begin_f(1);
    send_word(1, 32'h01, 8, 1'b0, 1, -1);
    send_word(1, 32'h80, 8, 1'b0, 1, -1);
    send_word(1, 32'h3C, 8, 1'b0, 1, -1);
    send_word(1, 32'hFF, 8, 1'b0, 1, -1);
`ifdef SPI_RX_CHECKSUM_EN
    send_word(1, 32'hBC, 8, 1'b0, 1, -1);
`endif
    end_f(1);
    check("m1_dout", 64'(if1.data_out), 64'hFF3C8001);
    check("m1_valid_cnt", 64'(nv[1] - v0), 64'd1);
    check("m1_busy_end", 64'(if1.busy), 64'h0);
    check("m1_ferr_cnt", 64'(nf[1]), 64'd0);

`ifdef SPI_RX_CHECKSUM_EN
    v0 = nv[0];
    frame0(16'h0001, 16'h0002, -1);
    check("cs_ok_dout", 64'(if0.data_out), 64'h00020001);
    check("cs_ok_valid", 64'(nv[0] - v0), 64'd1);
    check("cs_ok_cerr", 64'(nc[0]), 64'd0);
    v0 = nv[0];
    begin_f(0);
    send_word(0, 32'h0001, 16, 1'b1, 0, -1);
    send_word(0, 32'h0002, 16, 1'b1, 0, -1);
    send_word(0, 32'h0004, 16, 1'b1, 0, -1);
    end_f(0);
    check("cs_bad_cerr", 64'(nc[0]), 64'd1);
    check("cs_bad_valid", 64'(nv[0] - v0), 64'd0);
    check("cs_bad_dout", 64'(if0.data_out), 64'h00020001);
`else
    check("nocs_cerr0", 64'(nc[0]), 64'd0);
    check("nocs_cerr1", 64'(nc[1]), 64'd0);
`endif

    begin_f(0);
    send_word(0, 32'h0000BEEF, 10, 1'b1, 0, -1);
    reset = 1'b0;
    cyc(2);
    check("mid_rst_dout0", 64'(if0.data_out), 64'h0);
    check("mid_rst_busy0", 64'(if0.busy), 64'h0);
    check("mid_rst_valid0", 64'(if0.data_valid), 64'h0);
    check("mid_rst_ferr0", 64'(if0.frame_error), 64'h0);
    check("mid_rst_dout1", 64'(if1.data_out), 64'h0);
    nss_p[0] = 1'b1;
    sck_p[0] = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc(12);
    v0 = nv[0];
    f0 = nf[0];
    frame0(16'hBEEF, 16'hCAFE, -1);
    check("pr_dout", 64'(if0.data_out), 64'hCAFEBEEF);
    check("pr_valid_cnt", 64'(nv[0] - v0), 64'd1);
    check("pr_ferr_cnt", 64'(nf[0] - f0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
